lsu_ctrl: RTL

- Load/store initiator for the pipelined CPU's MEM stage.
- Accepts one load or store request per transaction from EX over a valid/ready handshake.
- Drives the word-indexed data memory port: address, write_data, MemWrite, MemRead and read_data. The memory reads combinationally and writes on posedge.
- Adds byte/half/word access, sign/zero extension, read-modify-write for sub-word stores, and a fault flag for misaligned or out-of-range accesses.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_lane_merge.sv | 54 +++++
 rtl/lsu_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings and the fault predicate for the load/store
//               unit: access sizes, controller state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Access size encodings as presented on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Controller state encoding
    localparam int unsigned        STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] RD      = 2'd1;
    localparam logic [STATE_W-1:0] WR      = 2'd2;

    // A request faults when its size is reserved, it is misaligned for its
    // size, or its word index lies beyond the end of data memory.
    function automatic logic lsu_fault(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input int unsigned mem_words
    );
        logic w_misaligned;
        logic w_out_of_range;
        w_misaligned   = ((size == SZ_HALF) && addr[0]) ||
                         ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        w_out_of_range = ({2'b00, addr[31:2]} >= 32'(mem_words));
        return (size == SZ_RSVD) || w_misaligned || w_out_of_range;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_merge.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_merge
// Description : Byte/half/word lane extraction with sign/zero extension for
//               loads, and lane insertion into the memory word for stores.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_signed,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [4:0]  w_byte_sh;
    logic [4:0]  w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Bit offsets of the selected byte / half lane inside the word
    assign w_byte_sh = {lane, 3'b000};
    assign w_half_sh = {lane[1], 4'b0000};
    assign w_byte    = mem_word[w_byte_sh +: 8];
    assign w_half    = mem_word[w_half_sh +: 16];

    // Extend the selected lane for loads; splice wdata into it for stores
    always_comb begin
        load_data  = mem_word;
        store_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_data                = {{24{is_signed & w_byte[7]}}, w_byte};
                store_word               = mem_word;
                store_word[w_byte_sh +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data                 = {{16{is_signed & w_half[15]}}, w_half};
                store_word                = mem_word;
                store_word[w_half_sh +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = mem_word;
                store_word = wdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : MEM-stage load/store initiator. Accepts one request over a
//               valid/ready handshake, drives a word-indexed memory port,
//               performs read-modify-write for sub-word stores and flags
//               misaligned / out-of-range accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        stall,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [31:0] mem_read_data
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;
    logic [31:0] r_merged;
    logic [31:0] r_mem_addr;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_fault;

    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

    assign w_accept = req_valid & req_ready;
    assign w_fault  = lsu_fault(req_size, req_addr, MEM_WORDS);

    lsu_lane_merge u_lane_merge (
        .size       (r_size),
        .lane       (r_lane),
        .is_signed  (r_signed),
        .mem_word   (mem_read_data),
        .wdata      (r_wdata),
        .load_data  (w_load_data),
        .store_word (w_store_word)
    );

    // State register; reset returns to IDLE immediately, killing any strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next state: word stores skip the read, faults never leave IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_fault)
                    w_next_state = (req_write && (req_size == SZ_WORD)) ? WR : RD;
            end
            RD:      w_next_state = r_write ? WR : IDLE;
            WR:      w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake and memory strobes decoded purely from state
    always_comb begin
        req_ready      = 1'b0;
        mem_MemRead    = 1'b0;
        mem_MemWrite   = 1'b0;
        mem_write_data = '0;
        case (r_state)
            IDLE: req_ready = 1'b1;
            RD:   mem_MemRead = 1'b1;
            WR: begin
                mem_MemWrite   = 1'b1;
                mem_write_data = r_merged;
            end
            default: req_ready = 1'b0;
        endcase
    end

    assign stall       = req_valid & ~req_ready;
    assign mem_address = r_mem_addr;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_fault  = r_resp_fault;

    // Capture the request; the memory index only moves for real accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write    <= 1'b0;
            r_size     <= SZ_BYTE;
            r_signed   <= 1'b0;
            r_lane     <= 2'b00;
            r_wdata    <= '0;
            r_mem_addr <= '0;
        end else if (w_accept) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_lane   <= req_addr[1:0];
            r_wdata  <= req_wdata;
            if (!w_fault)
                r_mem_addr <= {2'b00, req_addr[31:2]};
        end
    end

    // Store word: full wdata at accept, replaced by the merged word in RD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_merged <= '0;
        else if (w_accept)
            r_merged <= req_wdata;
        else if ((r_state == RD) && r_write)
            r_merged <= w_store_word;
    end

    // One-cycle response pulse after the final access, or after a fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            r_resp_valid <= (w_accept & w_fault) |
                            ((r_state == RD) & ~r_write) |
                            (r_state == WR);
            r_resp_fault <= w_accept & w_fault;
            r_resp_rdata <= ((r_state == RD) && !r_write) ? w_load_data : '0;
        end
    end

endmodule
`default_nettype wire
